sdfm_result_arbiter: RTL and testbench
======================================

Name: sdfm_result_arbiter

Overview:
- Collects filtered results from the NCH sigma-delta channels into per-channel holding registers.
- Shares the single register-map read path between the channels: a round-robin arbiter presents one pending result at a time over a valid/ready handshake.
- Tracks per-channel overrun and generates the module-level interrupt request.
- Sits between the CHANNEL instances and REGMAP; runs in the SYSCLK domain.

Parameters:
- NCH, 2, number of sigma-delta channels (≥2).
- DW, 32, result word width.

Ports:
- SYSCLK  input  1  system clock.
- SYSRSTn  input  1  system reset, asynchronous, active-low.
- ch_data  input  NCH*DW  filter results; channel i occupies [DW-1+i*DW : i*DW].
- ch_valid  input  NCH  one-cycle strobe per channel; the matching ch_data slice is valid in that cycle.
- reg_filten  input  NCH  channel enable, from DFPARMx.
- reg_filtask  input  NCH  interrupt enable for "result pending", from DFPARMx.
- ovf_clr  input  NCH  one-cycle write-1-to-clear strobe for the overrun flags.
- res_ready  input  1  register map accepts the presented result.
- res_valid  output  1  a result is being presented.
- res_data  output  DW  presented result.
- res_chan  output  clog2(NCH)  source channel of the presented result.
- ovf  output  NCH  sticky overrun flags.
- IRQ  output  1  interrupt request, registered level.

Behaviour:
- Reset (asynchronous on SYSRSTn low):
  - pending, hold, ovf, res_valid and IRQ all 0; res_data 0; res_chan 0.
  - FSM in IDLE; last_grant = NCH-1, so channel 0 wins first.
- Capture, per channel i at each SYSCLK edge:
  - If ch_valid[i] & reg_filten[i]: hold[i] <= ch_data slice and pending[i] <= 1.
  - If pending[i] was already 1 and is not being consumed this cycle, ovf[i] <= 1 and the newest data wins.
  - If ch_valid[i] arrives while reg_filten[i] = 0, it is ignored.
- Same-channel capture and handshake in one cycle: the old value transfers, the new value is captured, pending[i] stays 1, and no overrun is flagged.
- Disable: reg_filten[i] = 0 clears pending[i] at the next edge. hold[i] is retained; ovf[i] is untouched.
- FSM states: IDLE and OFFER.
  - IDLE: if any pending bit is set, grant the first pending channel searching upward from last_grant+1 (modulo NCH). Latch grant and go to OFFER. res_valid is 0 in IDLE.
  - OFFER: res_valid = 1, res_chan = grant, res_data = hold[grant]. res_data is driven combinationally from hold, so an overwrite during OFFER is visible immediately.
  - OFFER, res_ready = 1: transfer completes, pending[grant] clears (except the simultaneous-capture case above), last_grant <= grant, return to IDLE.
  - OFFER, reg_filten[grant] drops: return to IDLE and drop res_valid next cycle. If res_ready is high in that same cycle, the transfer still counts and last_grant updates.
  - Grant is fixed while in OFFER; no preemption.
- Latency and throughput:
  - ch_valid at edge N → pending set at N → OFFER entered at edge N+1 → res_valid high in cycle N+1..N+2.
  - With res_ready held high, at most one result every 2 cycles.
- Overrun flags:
  - ovf[i] is sticky until ovf_clr[i].
  - If set and clear occur in the same cycle, set wins.
- IRQ: registered as IRQ <= OR over i of ((pending[i] & reg_filtask[i]) | ovf[i]), one cycle behind the flags.
- Reset mid-operation: everything returns to reset values immediately. In-flight results are discarded without a handshake.
- res_valid does not drop in OFFER without either a handshake or a disable.

Test Plan:
- Single result: ch_valid=01, ch_data[31:0]=0x00001234, res_ready=1.
  - Expect res_valid=1 two cycles later, res_data=0x00001234, res_chan=0.
  - pending clears; IRQ pulses only if reg_filtask[0]=1.
- Fairness: both channels strobe in the same cycle (ch0=0xA, ch1=0xB), res_ready=1.
  - Expect ch0 then ch1 delivered.
  - Repeat the double strobe: expect ch1 first? No — last_grant=1, so ch0 first again. Strobe ch1 only after a ch1 grant and check that ch0 pending wins next.
- Overrun: strobe ch1 with 0x1, then 0x2 while res_ready=0.
  - Expect ovf=10 and IRQ=1; on res_ready, res_data=0x2.
  - Then ovf_clr=10 with no new strobe → ovf=00 and IRQ=0 one cycle later.
- Capture during handshake: hold ch0 in OFFER, then pulse res_ready and ch_valid[0]=0x55 in the same cycle.
  - Expect no ovf and pending[0] still 1; next offer carries 0x55.
- Disable in OFFER: ch0 offered with res_ready=0, then deassert reg_filten[0].
  - Expect res_valid=0 next cycle, pending[0]=0, FSM back in IDLE; a later ch0 strobe is ignored.
- Async reset: assert SYSRSTn=0 mid-OFFER, asynchronously to SYSCLK.
  - Expect res_valid, IRQ and ovf at 0 immediately.
  - After release, the first grant goes to ch0.

Source files
------------

// File: rtl/sdfm_result_arbiter.sv
// sdfm_result_arbiter: per-channel result holding, round-robin
// delivery to the register map, overrun flags and interrupt.
//
// Ports:
//   SYSCLK, SYSRSTn   system clock, async active-low reset
//   ch_data/ch_valid  filter results and one-cycle strobes
//   reg_filten        channel enable
//   reg_filtask       "result pending" interrupt enable
//   ovf_clr           write-1-to-clear strobes for ovf
//   res_ready         register map accepts presented result
//   res_valid/data    presented result
//   res_chan          source channel of presented result
//   ovf               sticky overrun flags
//   IRQ               registered interrupt request
module sdfm_result_arbiter #(
  parameter int NCH = 2,
  parameter int DW  = 32
) (
  input  logic                     SYSCLK,
  input  logic                     SYSRSTn,
  input  logic [NCH*DW-1:0]        ch_data,
  input  logic [NCH-1:0]           ch_valid,
  input  logic [NCH-1:0]           reg_filten,
  input  logic [NCH-1:0]           reg_filtask,
  input  logic [NCH-1:0]           ovf_clr,
  input  logic                     res_ready,
  output logic                     res_valid,
  output logic [DW-1:0]            res_data,
  output logic [$clog2(NCH)-1:0]   res_chan,
  output logic [NCH-1:0]           ovf,
  output logic                     IRQ
);

  localparam int CW = $clog2(NCH);

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   grant_q;
  logic [CW-1:0]   grant_d;
  logic [CW-1:0]   last_q;
  logic [CW-1:0]   last_d;
  logic [CW-1:0]   pick;
  logic [CW-1:0]   cand;
  logic            found;
  int              idx;

  logic [NCH-1:0]  pending_q;
  logic [NCH-1:0]  pending_d;
  logic [DW-1:0]   hold_q [NCH];
  logic [NCH-1:0]  ovf_q;
  logic [NCH-1:0]  ovf_d;
  logic            irq_q;
  logic            irq_d;

  logic            xfer;
  logic [NCH-1:0]  cap;
  logic [NCH-1:0]  take;
  logic [NCH-1:0]  ovf_set;

  // Round-robin search: first pending channel above last_q,
  // wrapping modulo NCH.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx  = (int'(last_q) + k) % NCH;
      cand = CW'(idx);
      if (!found && pending_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = OFFER;
        end
      end
      OFFER: begin
        // A handshake counts even when the channel is
        // being disabled in the same cycle.
        if (res_ready) begin
          last_d = grant_q;
        end
        if (res_ready || !reg_filten[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    xfer      = (state_q == OFFER) && res_ready;
    cap       = '0;
    take      = '0;
    ovf_set   = '0;
    pending_d = '0;
    for (int i = 0; i < NCH; i++) begin
      cap[i]  = ch_valid[i] & reg_filten[i];
      take[i] = xfer && (grant_q == CW'(i));
      // A capture on the cycle its predecessor is taken
      // is a refill, not an overrun.
      ovf_set[i]   = cap[i] & pending_q[i] & ~take[i];
      pending_d[i] = reg_filten[i]
                   & (cap[i] | (pending_q[i] & ~take[i]));
    end
    // Set dominates a simultaneous clear.
    ovf_d = ovf_set | (ovf_q & ~ovf_clr);
    irq_d = |((pending_q & reg_filtask) | ovf_q);
  end

  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= CW'(NCH - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      pending_q <= '0;
      ovf_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
    end
  end

  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      for (int i = 0; i < NCH; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cap[i]) begin
          hold_q[i] <= ch_data[i*DW +: DW];
        end
      end
    end
  end

  // res_data follows hold directly so an overwrite during
  // OFFER is visible at once.
  assign res_valid = (state_q == OFFER);
  assign res_data  = res_valid ? hold_q[grant_q] : '0;
  assign res_chan  = res_valid ? grant_q : '0;
  assign ovf       = ovf_q;
  assign IRQ       = irq_q;

endmodule

// File: tb/tb_sdfm_result_arbiter.sv
// tb_sdfm_result_arbiter: vector table, directed corner
// sequences and random traffic against a reference model.
module tb_sdfm_result_arbiter;

  logic        SYSCLK = 1'b0;
  logic        SYSRSTn;
  logic [63:0] ch_data;
  logic [1:0]  ch_valid;
  logic [1:0]  reg_filten;
  logic [1:0]  reg_filtask;
  logic [1:0]  ovf_clr;
  logic        res_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic [0:0]  res_chan;
  logic [1:0]  ovf;
  logic        IRQ;

  int n_cmp = 0;
  int n_bad = 0;

  sdfm_result_arbiter #(.NCH(2), .DW(32)) dut (
    .SYSCLK      (SYSCLK),
    .SYSRSTn     (SYSRSTn),
    .ch_data     (ch_data),
    .ch_valid    (ch_valid),
    .reg_filten  (reg_filten),
    .reg_filtask (reg_filtask),
    .ovf_clr     (ovf_clr),
    .res_ready   (res_ready),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_chan    (res_chan),
    .ovf         (ovf),
    .IRQ         (IRQ)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct {
    logic [1:0]  cv;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        rdy;
    logic [1:0]  tk;
    logic        ev;
    logic [31:0] ed;
    logic        ec;
    logic        ei;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic [1:0] cv, logic [31:0] d0, logic [31:0] d1,
    logic rdy, logic [1:0] tk, logic ev,
    logic [31:0] ed, logic ec, logic ei);
    vec_t v;
    v.cv = cv; v.d0 = d0; v.d1 = d1; v.rdy = rdy;
    v.tk = tk; v.ev = ev; v.ed = ed; v.ec = ec;
    v.ei = ei;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic step(input logic [1:0] cv,
                      input logic [31:0] d0,
                      input logic [31:0] d1,
                      input logic rdy,
                      input logic [1:0] clr);
    ch_valid  = cv;
    ch_data   = {d1, d0};
    res_ready = rdy;
    ovf_clr   = clr;
    tick();
  endtask

  task automatic idle(input logic rdy);
    step(2'b00, 32'h0, 32'h0, rdy, 2'b00);
  endtask

  // Reference model: transaction-level view of the arbiter.
  bit          m_pend[2];
  logic [31:0] m_hold[2];
  bit          m_ovf[2];
  bit          m_irq;
  bit          m_offer;
  int          m_g;
  int          m_last;

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_hold[i] = 0; m_ovf[i] = 0;
    end
    m_irq = 0; m_offer = 0; m_g = 0; m_last = 1;
  endtask

  task automatic m_step(input logic [1:0] cv,
                        input logic [63:0] d,
                        input logic [1:0] fen,
                        input logic [1:0] tk,
                        input logic [1:0] clr,
                        input logic rdy);
    bit hs;
    bit n_irq;
    bit n_offer;
    int n_g;
    int n_last;
    bit n_pend[2];
    bit n_ovf[2];
    hs = m_offer && rdy;
    n_irq = 0;
    for (int i = 0; i < 2; i++)
      if ((m_pend[i] && tk[i]) || m_ovf[i]) n_irq = 1;
    n_offer = m_offer; n_g = m_g; n_last = m_last;
    if (m_offer) begin
      if (rdy) n_last = m_g;
      if (rdy || !fen[m_g]) n_offer = 0;
    end else begin
      for (int k = 1; k <= 2; k++) begin
        int c;
        c = (m_last + k) % 2;
        if (!n_offer && m_pend[c]) begin
          n_offer = 1; n_g = c;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      bit capd;
      bit used;
      capd = cv[i] && fen[i];
      used = hs && (m_g == i);
      n_ovf[i] = m_ovf[i];
      if (capd && m_pend[i] && !used) n_ovf[i] = 1;
      else if (clr[i]) n_ovf[i] = 0;
      if (!fen[i]) n_pend[i] = 0;
      else if (capd) n_pend[i] = 1;
      else if (used) n_pend[i] = 0;
      else n_pend[i] = m_pend[i];
      if (capd) m_hold[i] = d[i*32 +: 32];
    end
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = n_pend[i]; m_ovf[i] = n_ovf[i];
    end
    m_irq = n_irq; m_offer = n_offer;
    m_g = n_g; m_last = n_last;
  endtask

  task automatic do_reset();
    SYSRSTn   = 1'b0;
    ch_valid  = '0;
    ch_data   = '0;
    ovf_clr   = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge SYSCLK);
    @(negedge SYSCLK);
    SYSRSTn = 1'b1;
    tick();
  endtask

  initial begin
    reg_filten  = 2'b11;
    reg_filtask = 2'b00;
    do_reset();
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_chan", res_chan, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_irq", IRQ, 0);

    // fairness
    tbl.push_back(mk(2'b11, 32'hA, 32'hB, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 32'hA, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 32'hB, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2'b11, 32'hC, 32'hD, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 32'hC, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 32'hD, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2'b10, 0, 32'hF, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'hF, 1, 0));
    tbl.push_back(mk(2'b01, 32'h10, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2'b10, 0, 32'h11, 1, 0, 1, 32'h10, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 32'h11, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    // single result, pending interrupt enabled
    tbl.push_back(mk(2'b01, 32'h1234, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h1234, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    // single result, pending interrupt masked
    tbl.push_back(mk(2'b01, 32'h1234, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 32'h1234, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));

    foreach (tbl[r]) begin
      reg_filtask = tbl[r].tk;
      step(tbl[r].cv, tbl[r].d0, tbl[r].d1,
           tbl[r].rdy, 2'b00);
      chk($sformatf("tbl%0d_valid", r), res_valid,
          tbl[r].ev);
      if (tbl[r].ev) begin
        chk($sformatf("tbl%0d_data", r), res_data,
            tbl[r].ed);
        chk($sformatf("tbl%0d_chan", r), res_chan,
            tbl[r].ec);
      end
      chk($sformatf("tbl%0d_ovf", r), ovf, 0);
      chk($sformatf("tbl%0d_irq", r), IRQ, tbl[r].ei);
    end
    reg_filtask = 2'b00;

    // overrun on ch1, newest data wins
    step(2'b10, 0, 32'h1, 0, 0);
    step(2'b10, 0, 32'h2, 0, 0);
    chk("ovr_ovf", ovf, 2'b10);
    chk("ovr_valid", res_valid, 1);
    chk("ovr_chan", res_chan, 1);
    idle(0);
    chk("ovr_irq", IRQ, 1);
    chk("ovr_data", res_data, 32'h2);
    idle(1);
    chk("ovr_done", res_valid, 0);
    step(0, 0, 0, 0, 2'b10);
    chk("ovr_clr", ovf, 0);
    idle(0);
    chk("ovr_irq_clr", IRQ, 0);
    // set wins over clear
    step(2'b10, 0, 32'h3, 0, 0);
    step(2'b10, 0, 32'h4, 0, 2'b10);
    chk("ovr_setwin", ovf, 2'b10);
    idle(1);
    step(0, 0, 0, 0, 2'b10);
    idle(0);
    chk("ovr_clean", ovf, 0);
    chk("ovr_irq0", IRQ, 0);

    // capture on ch0 during its own handshake
    step(2'b01, 32'h44, 0, 0, 0);
    idle(0);
    chk("cap_valid", res_valid, 1);
    chk("cap_old", res_data, 32'h44);
    step(2'b01, 32'h55, 0, 1, 0);
    chk("cap_hs", res_valid, 0);
    chk("cap_noovf", ovf, 0);
    idle(0);
    chk("cap_reoffer", res_valid, 1);
    chk("cap_new", res_data, 32'h55);
    chk("cap_chan", res_chan, 0);
    idle(1);
    chk("cap_done", res_valid, 0);

    // disable while offering
    step(2'b01, 32'h66, 0, 0, 0);
    idle(0);
    chk("dis_offer", res_valid, 1);
    reg_filten = 2'b10;
    idle(0);
    chk("dis_drop", res_valid, 0);
    step(2'b01, 32'h77, 0, 0, 0);
    idle(0);
    chk("dis_ignored", res_valid, 0);
    idle(0);
    chk("dis_idle", res_valid, 0);
    chk("dis_ovf", ovf, 0);
    reg_filten = 2'b11;
    idle(0);
    chk("dis_reen", res_valid, 0);

    // asynchronous reset mid-offer
    step(2'b10, 0, 32'h88, 0, 0);
    step(2'b10, 0, 32'h99, 0, 0);
    idle(0);
    chk("ar_pre_valid", res_valid, 1);
    chk("ar_pre_irq", IRQ, 1);
    chk("ar_pre_ovf", ovf, 2'b10);
    #3;
    SYSRSTn = 1'b0;
    #1;
    chk("ar_valid", res_valid, 0);
    chk("ar_irq", IRQ, 0);
    chk("ar_ovf", ovf, 0);
    chk("ar_data", res_data, 0);
    @(negedge SYSCLK);
    SYSRSTn = 1'b1;
    step(2'b11, 32'h1, 32'h2, 0, 0);
    idle(0);
    chk("ar_first_valid", res_valid, 1);
    chk("ar_first_chan", res_chan, 0);
    chk("ar_first_data", res_data, 32'h1);

    // random traffic against the model
    do_reset();
    m_reset();
    for (int n = 0; n < 600; n++) begin
      logic [1:0]  cv;
      logic [1:0]  fen;
      logic [1:0]  clr;
      logic [63:0] d;
      logic        rdy;
      for (int i = 0; i < 2; i++) begin
        cv[i]  = ($urandom_range(0, 2) == 0);
        fen[i] = ($urandom_range(0, 9) != 0);
        clr[i] = ($urandom_range(0, 5) == 0);
      end
      d   = {$urandom, $urandom};
      rdy = ($urandom_range(0, 4) < 3);
      reg_filten  = fen;
      reg_filtask = 2'($urandom_range(0, 3));
      m_step(cv, d, fen, reg_filtask, clr, rdy);
      ch_valid  = cv;
      ch_data   = d;
      ovf_clr   = clr;
      res_ready = rdy;
      tick();
      chk("rnd_valid", res_valid, m_offer);
      if (m_offer) begin
        chk("rnd_chan", res_chan, m_g);
        chk("rnd_data", res_data, m_hold[m_g]);
      end
      chk("rnd_ovf", ovf, {m_ovf[1], m_ovf[0]});
      chk("rnd_irq", IRQ, m_irq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
